// File: rtl/line_matrix_pkg.sv
// Shared definitions for the line matrix: select encoding and the commit FSM states.
package line_matrix_pkg;

  // Select encoding: 0 and 1 are constants, input line k is SEL_INPUT_BASE + k.
  localparam int SEL_CONST0     = 0;
  localparam int SEL_CONST1     = 1;
  localparam int SEL_INPUT_BASE = 2;

  // Commit sequencer: IDLE accepts writes, APPLY copies shadow to active for one cycle.
  typedef enum logic {
    ST_IDLE,
    ST_APPLY
  } state_t;

endpackage

// File: rtl/line_sync.sv
// Parametrised-width two-flop synchronizer. Both stages clear on reset so
// nothing stale reaches the crossbar after reset.
module line_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; only the second stage is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/line_crossbar.sv
// NUM_INPUTS x NUM_OUTPUTS single-bit line crossbar with registered outputs.
// Routing is written into shadow selects and copied to the active selects for
// all outputs at once on a commit strobe.
// Optional feature: define LINE_CROSSBAR_SYNC_EN to put a two-flop synchronizer
// on every input line (adds 2 cycles of latency, for asynchronous sources).
module line_crossbar
  import line_matrix_pkg::*;
#(
  parameter  int NUM_INPUTS  = 10,
  parameter  int NUM_OUTPUTS = 10,
  localparam int SEL_W       = $clog2(NUM_INPUTS + 2),
  localparam int OUT_W       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_INPUTS-1:0]  input_lines,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [OUT_W-1:0]       cfg_output,
  input  logic [SEL_W-1:0]       cfg_select,
  input  logic                   cfg_commit,
  output logic                   cfg_err,
  input  logic [OUT_W-1:0]       rd_output,
  output logic [SEL_W-1:0]       rd_select,
  output logic [NUM_OUTPUTS-1:0] output_lines
);

  logic [NUM_INPUTS-1:0] mux_lines;

`ifdef LINE_CROSSBAR_SYNC_EN
  line_sync #(.WIDTH(NUM_INPUTS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (input_lines),
    .q   (mux_lines)
  );
`else
  assign mux_lines = input_lines;
`endif

  state_t state;
  state_t state_next;
  logic   apply;

  logic [SEL_W-1:0] shadow_sel [NUM_OUTPUTS];
  logic [SEL_W-1:0] active_sel [NUM_OUTPUTS];

  logic                  wr_fire;
  logic                  wr_ok;
  logic [NUM_INPUTS+1:0] sources;

  // Select value s picks bit s of this vector: const 0, const 1, then the lines.
  assign sources = {mux_lines, 1'b1, 1'b0};
  assign wr_fire = cfg_valid && cfg_ready;
  assign wr_ok   = (int'(cfg_output) < NUM_OUTPUTS) &&
                   (int'(cfg_select) < SEL_INPUT_BASE + NUM_INPUTS);

  // State register for the commit sequencer.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake decode; a commit seen in APPLY is simply dropped.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    apply      = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_commit) state_next = ST_APPLY;
      end
      ST_APPLY: begin
        apply      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Shadow selects take accepted writes; active selects copy all shadows in APPLY.
  // A write accepted alongside a commit lands in shadow one edge before the copy,
  // so it is naturally part of that commit.
  // NOTE: the select arrays are tiny and must power up as const 0, so they are reset like any flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        shadow_sel[o] <= '0;
        active_sel[o] <= '0;
      end
    end else begin
      if (wr_fire && wr_ok) shadow_sel[cfg_output] <= cfg_select;
      if (apply)            active_sel <= shadow_sel;
    end
  end

  // Registered outputs: routed lines, error pulse and select readback.
  always_ff @(posedge clk) begin
    if (rst) begin
      output_lines <= '0;
      cfg_err      <= 1'b0;
      rd_select    <= '0;
    end else begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        output_lines[o] <= sources[active_sel[o]];
      end
      cfg_err   <= wr_fire && !wr_ok;
      rd_select <= (int'(rd_output) < NUM_OUTPUTS) ? active_sel[rd_output] : '0;
    end
  end

endmodule

// File: tb/tb_line_crossbar.sv
// Self-checking bench for line_crossbar: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model of the routing rules.
module tb_line_crossbar;

  localparam int NI    = 10;
  localparam int NO    = 10;
  localparam int SEL_W = $clog2(NI + 2);
  localparam int OUT_W = (NO > 1) ? $clog2(NO) : 1;
`ifdef LINE_CROSSBAR_SYNC_EN
  localparam int LAT   = 3;
`else
  localparam int LAT   = 1;
`endif

  logic             clk;
  logic             rst;
  logic [NI-1:0]    input_lines;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [OUT_W-1:0] cfg_output;
  logic [SEL_W-1:0] cfg_select;
  logic             cfg_commit;
  logic             cfg_err;
  logic [OUT_W-1:0] rd_output;
  logic [SEL_W-1:0] rd_select;
  logic [NO-1:0]    output_lines;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  bit            m_apply;
  int            m_shadow [NO];
  int            m_active [NO];
  logic [NO-1:0] m_out;
  bit            m_err;
  int            m_rd;
  logic [NI-1:0] m_s1, m_s2;

  line_crossbar #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_lines  (input_lines),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_output   (cfg_output),
    .cfg_select   (cfg_select),
    .cfg_commit   (cfg_commit),
    .cfg_err      (cfg_err),
    .rd_output    (rd_output),
    .rd_select    (rd_select),
    .output_lines (output_lines)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Value an output carries for a given select: 0, 1 or input line sel-2.
  function automatic logic sel_value(int sel, logic [NI-1:0] lines);
    if (sel == 0) return 1'b0;
    if (sel == 1) return 1'b1;
    return lines[sel-2];
  endfunction

  // Advance one clock; the model computes what every register holds after the
  // edge from the inputs currently applied, then outputs are sampled 1 ns later.
  task automatic step();
    logic [NI-1:0] eff;
    logic [NO-1:0] n_out;
    int            n_shadow [NO];
    int            n_active [NO];
    bit            n_apply, n_err, accept, bad;
    int            n_rd;
    logic [NI-1:0] n_s1, n_s2;
`ifdef LINE_CROSSBAR_SYNC_EN
    eff = m_s2;
`else
    eff = input_lines;
`endif
    n_shadow = m_shadow;
    n_active = m_active;
    n_apply  = 1'b0;
    n_err    = 1'b0;
    n_rd     = 0;
    n_out    = '0;
    n_s1     = '0;
    n_s2     = '0;
    if (!rst) begin
      for (int o = 0; o < NO; o++) n_out[o] = sel_value(m_active[o], eff);
      if (int'(rd_output) < NO) n_rd = m_active[rd_output];
      accept = cfg_valid && !m_apply;
      bad    = (int'(cfg_output) >= NO) || (int'(cfg_select) > NI + 1);
      n_err  = accept && bad;
      if (accept && !bad) n_shadow[cfg_output] = int'(cfg_select);
      if (m_apply) n_active = m_shadow;
      n_apply = !m_apply && cfg_commit;
      n_s1    = input_lines;
      n_s2    = m_s1;
    end else begin
      for (int o = 0; o < NO; o++) begin
        n_shadow[o] = 0;
        n_active[o] = 0;
      end
    end
    @(posedge clk);
    #1;
    m_shadow = n_shadow;
    m_active = n_active;
    m_apply  = n_apply;
    m_err    = n_err;
    m_rd     = n_rd;
    m_out    = n_out;
    m_s1     = n_s1;
    m_s2     = n_s2;
  endtask

  task automatic idle_cfg();
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic write_cfg(int o, int s);
    cfg_valid  = 1'b1;
    cfg_output = OUT_W'(o);
    cfg_select = SEL_W'(s);
    step();
    cfg_valid  = 1'b0;
  endtask

  task automatic test_reset();
    idle_cfg();
    cfg_output  = '0;
    cfg_select  = '0;
    rd_output   = '0;
    input_lines = '1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++;
    if (output_lines !== '0) begin
      n_bad++; $display("FAIL reset_out: got %h want 0", output_lines);
    end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", cfg_ready);
    end
    n_cmp++;
    if (cfg_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_err: got %b want 0", cfg_err);
    end
    for (int r = 0; r < (1 << OUT_W); r++) begin
      rd_output = OUT_W'(r);
      step();
      n_cmp++;
      if (rd_select !== '0) begin
        n_bad++; $display("FAIL reset_rd[%0d]: got %0d want 0", r, rd_select);
      end
      n_cmp++;
      if (output_lines !== '0) begin
        n_bad++; $display("FAIL reset_hold_out: got %h want 0", output_lines);
      end
    end
  endtask

  task automatic test_routing();
    input_lines = '0;
    write_cfg(3, 2 + 5);
    write_cfg(0, 1);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    input_lines = NI'(1) << 5;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_bad++; $display("FAIL route_apply_ready: got %b want 0", cfg_ready);
    end
    step();
    n_cmp++;
    if (output_lines !== '0) begin
      n_bad++; $display("FAIL route_commit1: got %h want 0", output_lines);
    end
    step();
    n_cmp++;
    if (output_lines !== NO'('b1001)) begin
      n_bad++; $display("FAIL route_commit2: got %h want %h", output_lines, NO'('b1001));
    end
    n_cmp++;
    if (output_lines !== m_out) begin
      n_bad++; $display("FAIL route_model: got %h want %h", output_lines, m_out);
    end
  endtask

  task automatic test_atomicity();
    input_lines = '0;
    write_cfg(1, 2 + 0);
    write_cfg(2, 2 + 1);
    for (int i = 0; i < 4; i++) begin
      input_lines = NI'($urandom);
      step();
      n_cmp++;
      if (output_lines[2:1] !== 2'b00 || output_lines !== m_out) begin
        n_bad++; $display("FAIL atomic_hold: got %h want %h", output_lines, m_out);
      end
    end
    input_lines = NI'('b11);
    cfg_commit  = 1'b1;
    step();
    cfg_commit  = 1'b0;
    step();
    n_cmp++;
    if (output_lines[2:1] !== 2'b00) begin
      n_bad++; $display("FAIL atomic_old: got %b want 00", output_lines[2:1]);
    end
    step();
    n_cmp++;
    if (output_lines[2:1] !== 2'b11) begin
      n_bad++; $display("FAIL atomic_new: got %b want 11", output_lines[2:1]);
    end
  endtask

  task automatic test_simul_commit();
    input_lines = '0;
    cfg_valid   = 1'b1;
    cfg_output  = OUT_W'(4);
    cfg_select  = SEL_W'(1);
    cfg_commit  = 1'b1;
    step();
    cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_bad++; $display("FAIL simul_ready_low: got %b want 0", cfg_ready);
    end
    // commit still held high in APPLY must be ignored
    step();
    cfg_commit = 1'b0;
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL simul_ready_back: got %b want 1", cfg_ready);
    end
    n_cmp++;
    if (output_lines[4] !== 1'b0) begin
      n_bad++; $display("FAIL simul_out4_early: got %b want 0", output_lines[4]);
    end
    step();
    n_cmp++;
    if (output_lines[4] !== 1'b1) begin
      n_bad++; $display("FAIL simul_out4: got %b want 1", output_lines[4]);
    end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL simul_no_reapply: got %b want 1", cfg_ready);
    end
  endtask

  task automatic test_rejection();
    write_cfg(NO, 3);
    n_cmp++;
    if (cfg_err !== 1'b1) begin
      n_bad++; $display("FAIL rej_out_err: got %b want 1", cfg_err);
    end
    step();
    n_cmp++;
    if (cfg_err !== 1'b0) begin
      n_bad++; $display("FAIL rej_out_pulse: got %b want 0", cfg_err);
    end
    write_cfg(0, NI + 2);
    n_cmp++;
    if (cfg_err !== 1'b1) begin
      n_bad++; $display("FAIL rej_sel_err: got %b want 1", cfg_err);
    end
    step();
    n_cmp++;
    if (cfg_err !== 1'b0) begin
      n_bad++; $display("FAIL rej_sel_pulse: got %b want 0", cfg_err);
    end
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    step();
    for (int r = 0; r < NO; r++) begin
      rd_output = OUT_W'(r);
      step();
      n_cmp++;
      if (rd_select !== SEL_W'(m_rd)) begin
        n_bad++; $display("FAIL rej_rd[%0d]: got %0d want %0d", r, rd_select, m_rd);
      end
      if (r == 0) begin
        n_cmp++;
        if (rd_select !== SEL_W'(1)) begin
          n_bad++; $display("FAIL rej_rd0_kept: got %0d want 1", rd_select);
        end
      end
    end
  endtask

  task automatic test_mid_commit_reset();
    write_cfg(5, 1);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (output_lines !== '0 || cfg_ready !== 1'b1 || cfg_err !== 1'b0 || rd_select !== '0) begin
      n_bad++; $display("FAIL midrst_state: out %h ready %b err %b rd %0d want 0/1/0/0",
                        output_lines, cfg_ready, cfg_err, rd_select);
    end
    for (int r = 0; r < NO; r++) begin
      rd_output = OUT_W'(r);
      step();
      n_cmp++;
      if (rd_select !== '0 || output_lines !== '0) begin
        n_bad++; $display("FAIL midrst_rd[%0d]: rd %0d out %h want 0/0", r, rd_select, output_lines);
      end
    end
  endtask

  task automatic test_latency();
    input_lines = '0;
    write_cfg(0, 2 + 0);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    for (int i = 0; i < 3; i++) step();
    input_lines[0] = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      step();
      n_cmp++;
      if (output_lines[0] !== (k >= LAT)) begin
        n_bad++; $display("FAIL latency_k%0d: got %b want %b", k, output_lines[0], (k >= LAT));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 59) == 0);
      input_lines = NI'($urandom);
      cfg_valid   = ($urandom_range(0, 1) == 1);
      cfg_output  = ($urandom_range(0, 4) == 0) ? OUT_W'($urandom) : OUT_W'($urandom_range(0, NO - 1));
      cfg_select  = ($urandom_range(0, 4) == 0) ? SEL_W'($urandom) : SEL_W'($urandom_range(0, NI + 1));
      cfg_commit  = ($urandom_range(0, 4) == 0);
      rd_output   = OUT_W'($urandom);
      step();
      n_cmp++;
      if (output_lines !== m_out) begin
        n_bad++; $display("FAIL rand_out c%0d: got %h want %h", c, output_lines, m_out);
      end
      n_cmp++;
      if (cfg_ready !== !m_apply) begin
        n_bad++; $display("FAIL rand_ready c%0d: got %b want %b", c, cfg_ready, !m_apply);
      end
      n_cmp++;
      if (cfg_err !== m_err) begin
        n_bad++; $display("FAIL rand_err c%0d: got %b want %b", c, cfg_err, m_err);
      end
      n_cmp++;
      if (rd_select !== SEL_W'(m_rd)) begin
        n_bad++; $display("FAIL rand_rd c%0d: got %0d want %0d", c, rd_select, m_rd);
      end
    end
    rst = 1'b0;
    idle_cfg();
    step();
  endtask

  initial begin
    rst         = 1'b1;
    input_lines = '0;
    idle_cfg();
    cfg_output  = '0;
    cfg_select  = '0;
    rd_output   = '0;
    m_apply     = 1'b0;
    m_err       = 1'b0;
    m_rd        = 0;
    m_out       = '0;
    m_s1        = '0;
    m_s2        = '0;
    for (int o = 0; o < NO; o++) begin
      m_shadow[o] = 0;
      m_active[o] = 0;
    end
    test_reset();
    test_routing();
    test_atomicity();
    test_simul_commit();
    test_rejection();
    test_mid_commit_reset();
    test_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_crossbar.md
# line_crossbar

Parametrised NUM_INPUTS×NUM_OUTPUTS single-bit line crossbar for the line matrix. It routes any input line, or a constant 0/1, to every output line, with registered outputs. Routing is written through a valid/ready config port into shadow registers and applied atomically on a commit strobe. It sits between external/GPIO trigger lines and downstream consumers, with a register bridge driving the config port.

## Interface
- NUM_INPUTS, 10, number of routable input lines (≥1)
- NUM_OUTPUTS, 10, number of output lines (≥1)
- SEL_W, $clog2(NUM_INPUTS+2), select width (derived, not overridden)
- OUT_W, max(1,$clog2(NUM_OUTPUTS)), output-address width (derived)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- input_lines  in  NUM_INPUTS  lines to route
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when high with cfg_valid
- cfg_output  in  OUT_W  output index to configure
- cfg_select  in  SEL_W  0 = const 0, 1 = const 1, 2+k = input_lines[k]
- cfg_commit  in  1  one-cycle strobe: copy all shadow selects to active
- cfg_err  out  1  one-cycle pulse on a rejected write
- rd_output  in  OUT_W  readback address
- rd_select  out  SEL_W  active select of rd_output, registered
- output_lines  out  NUM_OUTPUTS  routed lines, registered

## Operation
- Per output o: shadow_sel[o] and active_sel[o]. Reset: both 0, so every output drives constant 0.
- Write: accepted on cfg_valid && cfg_ready. Sets shadow_sel[cfg_output] = cfg_select. Active routing is unchanged.
- Rejection: a write with cfg_output ≥ NUM_OUTPUTS or cfg_select > NUM_INPUTS+1 is consumed without effect. cfg_err pulses high the next cycle.
- Two-state FSM:
  - IDLE: cfg_ready=1.
  - cfg_commit moves IDLE→APPLY.
  - APPLY: cfg_ready=0 for exactly one cycle; active_sel ← shadow_sel for all outputs simultaneously; returns to IDLE.
- Simultaneous accepted write and commit in IDLE: the write is included in the commit (bypass into the copy).
- A commit strobe while in APPLY is ignored.
- output_lines[o] ← {input_lines, 1'b1, 1'b0}[active_sel[o]], registered.
- rd_select ← active_sel[rd_output]. Out-of-range rd_output returns 0.
- rst mid-operation (any state): FSM → IDLE, all selects 0, output_lines 0, cfg_err 0, rd_select 0. A pending commit is discarded.

## Timing
- Reset values: output_lines=0, cfg_ready=1, cfg_err=0, rd_select=0.
- Input to output latency: 1 cycle. With LINE_CROSSBAR_SYNC_EN: 3 cycles.
- Commit strobe at edge N: FSM in APPLY during cycle N+1. active_sel updates at edge N+1. output_lines show the new routing from edge N+2. No output ever mixes old and new selections across outputs.
- cfg_err: asserted in the cycle after the rejected write, for 1 cycle.
- Readback latency: 1 cycle from rd_output.

## Configuration
- LINE_CROSSBAR_SYNC_EN defined:
  - each input_lines bit passes through a two-flop synchronizer (reset to 0) before the mux;
  - adds 2 cycles of latency;
  - required for asynchronous sources.
- LINE_CROSSBAR_SYNC_EN undefined: inputs feed the mux directly; inputs must be synchronous to clk.

## Structure
- Shared package line_matrix_pkg:
  - SEL_CONST0=0, SEL_CONST1=1, SEL_INPUT_BASE=2;
  - FSM state typedef {ST_IDLE, ST_APPLY}.
- Sub-module line_sync: parametrised-width two-flop synchronizer, instantiated only under LINE_CROSSBAR_SYNC_EN.

## Test plan
- Reset: assert rst 2 cycles with input_lines all ones → output_lines=0, cfg_ready=1, rd_select=0 for every rd_output.
- Routing: write out3←sel 2+5, out0←sel 1, then commit; drive input_lines[5]=1 → out3=1 and out0=1 at commit+2. Remaining outputs stay 0.
- Atomicity: write out1←sel 2+0 and out2←sel 2+1 without commit, toggle inputs → outputs unchanged. After commit, both switch on the same edge.
- Simultaneous write+commit: write out4←sel 1 in the commit cycle → out4=1 at commit+2. cfg_ready low exactly 1 cycle.
- Rejection: write cfg_output=NUM_OUTPUTS, then cfg_select=NUM_INPUTS+2 → cfg_err pulses once per write. Shadow and active state unchanged, verified via readback after commit.
- Mid-commit reset: commit, then rst in the APPLY cycle → all outputs 0, FSM IDLE, readback 0. With SYNC_EN, an input step reaches the output 3 cycles later.
